// File: rtl/pck_sink_checker_pkg.sv
// Shared definitions for the packet traffic generator and sink checker:
// width helper and sink FSM state encoding.
package pck_sink_checker_pkg;

    // Ceiling log2, never below 1 so derived buses stay at least one bit wide.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StInPck = 1'b1
    } sink_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments on inc and holds once it reaches Max.
module sat_counter #(
    parameter int unsigned Width = 8,
    parameter int unsigned Max   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [Width-1:0] count
);

    localparam logic [Width-1:0] MaxVal = Width'(Max);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != MaxVal)) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pck_sink_checker.sv
// Mesh endpoint packet sink: accepts every flit, checks protocol and
// destination, and accumulates packet count and latency statistics.
module pck_sink_checker
    import pck_sink_checker_pkg::*;
#(
    parameter int unsigned NX          = 4,
    parameter int unsigned NY          = 4,
    parameter int unsigned C           = 4,
    parameter int unsigned MAX_PCK_NUM = 10000,
    parameter int unsigned TIMEw       = 32,
    parameter int unsigned SUMw        = 48,
    localparam int unsigned Xw         = log2(NX),
    localparam int unsigned Yw         = log2(NY),
    localparam int unsigned NCw        = log2(NX * NY),
    localparam int unsigned Cw         = (C > 1) ? log2(C) : 1,
    localparam int unsigned PCK_CNTw   = log2(MAX_PCK_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [Xw-1:0]         current_x,
    input  logic [Yw-1:0]         current_y,
    input  logic [TIMEw-1:0]      time_now,
    input  logic                  flit_wr,
    input  logic                  flit_hdr,
    input  logic                  flit_tail,
    input  logic [NCw-1:0]        src_core,
    input  logic [Xw-1:0]         dst_x,
    input  logic [Yw-1:0]         dst_y,
    input  logic [Cw-1:0]         pck_class,
    input  logic [TIMEw-1:0]      send_time,
    output logic                  credit_out,
    output logic                  pck_done,
    output logic [TIMEw-1:0]      pck_latency,
    output logic [PCK_CNTw-1:0]   total_pck,
    output logic [C*PCK_CNTw-1:0] class_pck_cnt,
    output logic [SUMw-1:0]       sum_latency,
    output logic [TIMEw-1:0]      max_latency,
    output logic                  err_dst,
    output logic                  err_proto
);

    sink_state_e state_q, state_d;

    logic [TIMEw-1:0] send_q;
    logic [Cw-1:0]    cls_q;
    logic             credit_q, done_q, err_dst_q, err_proto_q;
    logic [TIMEw-1:0] latency_q, max_q;
    logic [SUMw-1:0]  sum_q, sum_d;
    logic [SUMw:0]    sum_ext;

    logic             hdr_fire, dst_bad, cls_bad, done_now, proto_set;
    logic [Cw-1:0]    cls_in, cur_cls;
    logic [TIMEw-1:0] cur_send, latency;

    // src_core is carried for the traffic generator's benefit; the sink ignores it.
    logic unused_src;
    assign unused_src = ^src_core;

    assign hdr_fire = flit_wr & flit_hdr;
    assign dst_bad  = (dst_x != current_x) || (dst_y != current_y);
    assign cls_bad  = 32'(pck_class) >= C;
    assign cls_in   = cls_bad ? Cw'(C - 1) : pck_class;

    // A header-and-tail flit completes using its own fields, not the latched ones.
    assign cur_send = hdr_fire ? send_time : send_q;
    assign cur_cls  = hdr_fire ? cls_in : cls_q;
    assign latency  = time_now - cur_send;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (hdr_fire) begin
            state_d = flit_tail ? StIdle : StInPck;
        end else if ((state_q == StInPck) && flit_wr && flit_tail) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        done_now  = 1'b0;
        proto_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                done_now  = hdr_fire & flit_tail;
                proto_set = flit_wr & ~flit_hdr;
            end
            StInPck: begin
                done_now  = flit_wr & flit_tail;
                proto_set = hdr_fire;
            end
            default: ;
        endcase
        proto_set = proto_set | (hdr_fire & cls_bad);
    end

    assign sum_ext = {1'b0, sum_q} + (SUMw + 1)'(latency);
    assign sum_d   = sum_ext[SUMw] ? '1 : sum_ext[SUMw-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            send_q      <= '0;
            cls_q       <= '0;
            credit_q    <= 1'b0;
            done_q      <= 1'b0;
            latency_q   <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            err_dst_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            credit_q <= flit_wr;
            done_q   <= done_now;
            if (hdr_fire) begin
                send_q <= send_time;
                cls_q  <= cls_in;
            end
            if (done_now) begin
                latency_q <= latency;
                sum_q     <= sum_d;
                if (latency > max_q) begin
                    max_q <= latency;
                end
            end
            if (hdr_fire && dst_bad) begin
                err_dst_q <= 1'b1;
            end
            if (proto_set) begin
                err_proto_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .Width(PCK_CNTw),
        .Max  (MAX_PCK_NUM)
    ) u_total_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (done_now),
        .count(total_pck)
    );

    for (genvar k = 0; k < C; k++) begin : g_class_cnt
        sat_counter #(
            .Width(PCK_CNTw),
            .Max  (MAX_PCK_NUM)
        ) u_class_cnt (
            .clk  (clk),
            .reset(reset),
            .inc  (done_now && (cur_cls == Cw'(k))),
            .count(class_pck_cnt[k*PCK_CNTw +: PCK_CNTw])
        );
    end

    assign credit_out  = credit_q;
    assign pck_done    = done_q;
    assign pck_latency = latency_q;
    assign sum_latency = sum_q;
    assign max_latency = max_q;
    assign err_dst     = err_dst_q;
    assign err_proto   = err_proto_q;

endmodule

// File: doc/pck_sink_checker.md
PCK_SINK_CHECKER -- requirements
Module: pck_sink_checker

Interface
REQ-001 Parameter NX, default 4, mesh columns.
REQ-002 Parameter NY, default 4, mesh rows.
REQ-003 Parameter C, default 4, number of packet classes (1..4).
REQ-004 Parameter MAX_PCK_NUM, default 10000, counter saturation value.
REQ-005 Parameter TIMEw, default 32, timestamp width.
REQ-006 Parameter SUMw, default 48, latency accumulator width.
REQ-007 Derived widths: Xw=log2(NX), Yw=log2(NY), NCw=log2(NX*NY), Cw=(C>1)?log2(C):1, PCK_CNTw=log2(MAX_PCK_NUM+1).
REQ-008 Port clk  input  1  single clock; all state updates on rising edge.
REQ-009 Port reset  input  1  asynchronous, active-high reset.
REQ-010 Ports current_x / current_y  input  Xw / Yw  own router address, static.
REQ-011 Port time_now  input  TIMEw  global free-running cycle counter.
REQ-012 Ports flit_wr / flit_hdr / flit_tail  input  1 each  flit valid, header marker, tail marker.
REQ-013 Ports src_core / dst_x / dst_y / pck_class / send_time  input  NCw / Xw / Yw / Cw / TIMEw  header fields, sampled only when flit_wr & flit_hdr.
REQ-014 Port credit_out  output  1  one credit returned per accepted flit.
REQ-015 Ports pck_done / pck_latency  output  1 / TIMEw  one-cycle completion pulse and that packet's latency.
REQ-016 Ports total_pck / class_pck_cnt  output  PCK_CNTw / C*PCK_CNTw  packets received; per-class counts, class k at bits [k*PCK_CNTw +: PCK_CNTw].
REQ-017 Ports sum_latency / max_latency  output  SUMw / TIMEw  latency statistics.
REQ-018 Ports err_dst / err_proto  output  1 each  sticky error flags.

Function
REQ-019 FSM states IDLE and IN_PCK; sink always accepts, no backpressure.
REQ-020 IDLE + flit_wr & flit_hdr & ~flit_tail -> IN_PCK; header fields latched.
REQ-021 IDLE + flit_wr & flit_hdr & flit_tail -> single-flit packet, completes that cycle, stays IDLE.
REQ-022 IN_PCK + flit_wr & flit_tail & ~flit_hdr -> packet completes, -> IDLE.
REQ-023 IDLE + flit_wr & ~flit_hdr -> err_proto set, flit dropped, stays IDLE.
REQ-024 IN_PCK + flit_wr & flit_hdr -> err_proto set, previous packet discarded uncounted, new header latched (single-flit: completes, -> IDLE).
REQ-025 credit_out = registered flit_wr: asserted exactly one cycle after every flit_wr cycle, including dropped flits.
REQ-026 Header with {dst_x,dst_y} != {current_x,current_y} sets err_dst; packet still counted.
REQ-027 On completion (tail cycle): latency = time_now - latched send_time, modulo 2^TIMEw (wrap-around correct).
REQ-028 pck_done and pck_latency registered: valid the cycle after tail acceptance.
REQ-029 Same update cycle as pck_done: total_pck and class_pck_cnt[class] increment, saturating at MAX_PCK_NUM.
REQ-030 sum_latency += latency, saturating at 2^SUMw-1; max_latency = max(max_latency, latency).
REQ-031 pck_class >= C counted in class C-1 and sets err_proto.
REQ-032 err_dst, err_proto clear only on reset.

Reset
REQ-033 Asserting reset asynchronously forces IDLE and clears all outputs and counters to 0, including any packet in flight and pending credit_out/pck_done.
REQ-034 Flits during reset ignored; no credit returned for them.

Structure
REQ-035 log2 function, derived width constants and FSM state encoding reside in a shared package for traffic generator and sink.
REQ-036 One sub-module, sat_counter (parameterized width and max, inc input), instantiated for total_pck and each class count.

Verification
REQ-037 4x4, own (1,2): 1-flit pck, dst (1,2), class 2, send_time 100, tail at time 130 -> next cycle pck_done=1, pck_latency=30, class_pck_cnt[2]=1, total_pck=1.
REQ-038 3-flit pck send_time 0xFFFFFFF0, tail at time 0x10 -> pck_latency=0x20; three credit_out pulses, each one cycle after its flit.
REQ-039 Body flit in IDLE -> err_proto=1, no pck_done, credit_out=1 next cycle; header mid-packet -> err_proto, total_pck excludes aborted packet.
REQ-040 Header dst (3,3) at own (1,2) -> err_dst=1 sticky, total_pck increments.
REQ-041 MAX_PCK_NUM=3, send 5 class-0 packets -> total_pck=3, class_pck_cnt[0]=3.
REQ-042 Reset asserted mid-packet between clock edges -> outputs 0 immediately; next header after release counted normally.
